// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: one write per cycle, arbitrating pixel writes against a
// raster-order full-frame fill. The fill engine is built only when FB_WRITE_SCHED_CLEAR_EN is defined.
module fb_write_sched #(
    parameter int ARB_RR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       px_valid,
    input  logic [7:0] px_x,
    input  logic [7:0] px_y,
    input  logic [7:0] px_pix,
    output logic       px_ready,
    input  logic       clear_start,
    input  logic [7:0] clear_color,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [7:0] wr_x,
    output logic [7:0] wr_y,
    output logic [7:0] wr_pix,
    output logic       wr_we
);

`ifdef FB_WRITE_SCHED_CLEAR_EN
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t      state;
    logic [15:0] sweep_cnt;
    logic [7:0]  fill_color;
    logic        last_px;
    logic        fill_req;
    logic        px_grant;
    logic        fill_grant;

    assign fill_req = (state == SWEEP);

    // Grants are gated by reset so px_ready stays low while rst_n is asserted.
    always_comb begin
        // NOTE: both grants get a default before any branch, so no path can infer a latch.
        px_grant   = 1'b0;
        fill_grant = 1'b0;
        if (rst_n) begin
            if (px_valid && fill_req) begin
                if (ARB_RR != 0) begin
                    px_grant   = !last_px;
                    fill_grant = last_px;
                end else begin
                    px_grant   = 1'b1;
                end
            end else begin
                px_grant   = px_valid;
                fill_grant = fill_req;
            end
        end
    end

    assign px_ready   = px_grant;
    assign clear_busy = fill_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sweep_cnt  <= 16'h0000;
            fill_color <= 8'h00;
            last_px    <= 1'b0;
            clear_done <= 1'b0;
            wr_we      <= 1'b0;
            wr_x       <= 8'h00;
            wr_y       <= 8'h00;
            wr_pix     <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_we      <= px_grant || fill_grant;
            clear_done <= 1'b0;
            if (px_grant) begin
                wr_x   <= px_x;
                wr_y   <= px_y;
                wr_pix <= px_pix;
            end else if (fill_grant) begin
                wr_x   <= sweep_cnt[7:0];
                wr_y   <= sweep_cnt[15:8];
                wr_pix <= fill_color;
            end
            if (px_grant || fill_grant) begin
                last_px <= px_grant;
            end
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= SWEEP;
                        fill_color <= clear_color;
                        sweep_cnt  <= 16'h0000;
                    end
                end
                SWEEP: begin
                    // A clear_start seen here is deliberately ignored.
                    if (fill_grant) begin
                        sweep_cnt <= sweep_cnt + 16'd1;
                        if (sweep_cnt == 16'hFFFF) begin
                            state      <= IDLE;
                            clear_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{clear_start, clear_color, (ARB_RR != 0)};
    assign px_ready      = px_valid && rst_n;
    assign clear_busy    = 1'b0;
    assign clear_done    = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_we  <= 1'b0;
            wr_x   <= 8'h00;
            wr_y   <= 8'h00;
            wr_pix <= 8'h00;
        end else begin
            wr_we <= px_ready;
            if (px_ready) begin
                wr_x   <= px_x;
                wr_y   <= px_y;
                wr_pix <= px_pix;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: three instances (round-robin x2, fixed priority) checked every
// cycle against a behavioural model, plus scenario checks for pixel, random and sweep traffic.
`timescale 1ns/1ps
module tb_fb_write_sched;

    localparam int N = 3;
`ifdef FB_WRITE_SCHED_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    localparam bit [N-1:0] ARB_SEL = 3'b011;

    typedef struct packed {
        bit       sweeping;
        int       cnt;
        bit [7:0] color;
        bit       last_px;
        bit       we;
        bit [7:0] x;
        bit [7:0] y;
        bit [7:0] pix;
        bit       done;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n       [N];
    logic       px_valid    [N];
    logic [7:0] px_x        [N];
    logic [7:0] px_y        [N];
    logic [7:0] px_pix      [N];
    logic       px_ready    [N];
    logic       clear_start [N];
    logic [7:0] clear_color [N];
    logic       clear_busy  [N];
    logic       clear_done  [N];
    logic [7:0] wr_x        [N];
    logic [7:0] wr_y        [N];
    logic [7:0] wr_pix      [N];
    logic       wr_we       [N];

    logic       obs_ready [N];
    logic       obs_we    [N];
    logic       obs_busy  [N];
    logic       obs_done  [N];
    logic [7:0] obs_x     [N];
    logic [7:0] obs_y     [N];
    logic [7:0] obs_pix   [N];
    bit         grant_px  [N];

    model_t m [N];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fb_write_sched #(.ARB_RR(1)) dut_rr_a (
        .clk(clk), .rst_n(rst_n[0]), .px_valid(px_valid[0]), .px_x(px_x[0]), .px_y(px_y[0]),
        .px_pix(px_pix[0]), .px_ready(px_ready[0]), .clear_start(clear_start[0]),
        .clear_color(clear_color[0]), .clear_busy(clear_busy[0]), .clear_done(clear_done[0]),
        .wr_x(wr_x[0]), .wr_y(wr_y[0]), .wr_pix(wr_pix[0]), .wr_we(wr_we[0])
    );

    fb_write_sched #(.ARB_RR(1)) dut_rr_b (
        .clk(clk), .rst_n(rst_n[1]), .px_valid(px_valid[1]), .px_x(px_x[1]), .px_y(px_y[1]),
        .px_pix(px_pix[1]), .px_ready(px_ready[1]), .clear_start(clear_start[1]),
        .clear_color(clear_color[1]), .clear_busy(clear_busy[1]), .clear_done(clear_done[1]),
        .wr_x(wr_x[1]), .wr_y(wr_y[1]), .wr_pix(wr_pix[1]), .wr_we(wr_we[1])
    );

    fb_write_sched #(.ARB_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n[2]), .px_valid(px_valid[2]), .px_x(px_x[2]), .px_y(px_y[2]),
        .px_pix(px_pix[2]), .px_ready(px_ready[2]), .clear_start(clear_start[2]),
        .clear_color(clear_color[2]), .clear_busy(clear_busy[2]), .clear_done(clear_done[2]),
        .wr_x(wr_x[2]), .wr_y(wr_y[2]), .wr_pix(wr_pix[2]), .wr_we(wr_we[2])
    );

    // Who wins this cycle: pixel vs. active sweep, alternating or pixel-first.
    function automatic void arbitrate(input model_t s, input bit rr, input bit rst, input bit pv,
                                      output bit gpx, output bit gfill);
        gpx   = 1'b0;
        gfill = 1'b0;
        if (!rst) return;
        if (pv && s.sweeping) begin
            if (!rr)            gpx   = 1'b1;
            else if (s.last_px) gfill = 1'b1;
            else                gpx   = 1'b1;
        end else begin
            gpx   = pv;
            gfill = s.sweeping;
        end
    endfunction

    function automatic model_t advance(input model_t s, input bit rst, input bit cs, input bit [7:0] cc,
                                       input bit [7:0] px, input bit [7:0] py, input bit [7:0] pp,
                                       input bit gpx, input bit gfill);
        model_t n = s;
        if (!rst) return '0;
        n.we   = gpx || gfill;
        n.done = 1'b0;
        if (gpx) begin
            n.x = px; n.y = py; n.pix = pp;
        end else if (gfill) begin
            n.x = 8'(s.cnt % 256); n.y = 8'(s.cnt / 256); n.pix = s.color;
        end
        if (gpx || gfill) n.last_px = gpx;
        if (CLEAR_EN && !s.sweeping && cs) begin
            n.sweeping = 1'b1; n.color = cc; n.cnt = 0;
        end else if (s.sweeping && gfill) begin
            if (s.cnt == 65535) begin
                n.sweeping = 1'b0; n.cnt = 0; n.done = 1'b1;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    // One clock: sample at negedge, compare every instance with its model, advance to posedge+1.
    task automatic cycle();
        logic [27:0] exp_v, obs_v;
        bit gpx, gfill;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            arbitrate(m[i], ARB_SEL[i], rst_n[i], px_valid[i], gpx, gfill);
            grant_px[i]  = gpx;
            obs_ready[i] = px_ready[i];
            obs_we[i]    = wr_we[i];
            obs_busy[i]  = clear_busy[i];
            obs_done[i]  = clear_done[i];
            obs_x[i]     = wr_x[i];
            obs_y[i]     = wr_y[i];
            obs_pix[i]   = wr_pix[i];
            exp_v = {gpx, m[i].we, m[i].x, m[i].y, m[i].pix, m[i].sweeping, m[i].done};
            obs_v = {px_ready[i], wr_we[i], wr_x[i], wr_y[i], wr_pix[i], clear_busy[i], clear_done[i]};
            n_checks++;
            if (obs_v !== exp_v)
                $display("FAIL model dut%0d @%0t: got {rdy,we,x,y,pix,busy,done}=%h expected %h",
                         i, $time, obs_v, exp_v);
            else n_pass++;
            m[i] = advance(m[i], rst_n[i], clear_start[i], clear_color[i],
                           px_x[i], px_y[i], px_pix[i], gpx, gfill);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_pixel(input int i, input bit [7:0] avoid);
        px_x[i]   = 8'($urandom);
        px_y[i]   = 8'($urandom);
        px_pix[i] = 8'($urandom);
        if (px_pix[i] == avoid) px_pix[i] = px_pix[i] ^ 8'h01;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; px_valid[i] = 1'b1; clear_start[i] = 1'b0; clear_color[i] = 8'h00;
            new_pixel(i, 8'h00);
            m[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        cycle();
        cycle();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (obs_ready[i] !== 1'b0) $display("FAIL reset_px_ready dut%0d: got %b expected 0", i, obs_ready[i]);
            else n_pass++;
            n_checks++;
            if ({obs_we[i], obs_x[i], obs_y[i], obs_pix[i], obs_busy[i], obs_done[i]} !== 28'h0)
                $display("FAIL reset_outputs dut%0d: we=%b x=%h y=%h pix=%h busy=%b done=%b expected all 0",
                         i, obs_we[i], obs_x[i], obs_y[i], obs_pix[i], obs_busy[i], obs_done[i]);
            else n_pass++;
            rst_n[i] = 1'b1; px_valid[i] = 1'b0;
        end
        cycle();
    endtask

    task automatic test_single_pixel();
        for (int i = 0; i < N; i++) begin
            px_valid[i] = 1'b1; px_x[i] = 8'h12; px_y[i] = 8'h34; px_pix[i] = 8'hE0;
        end
        cycle();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (obs_ready[i] !== 1'b1) $display("FAIL pixel_ready dut%0d: got %b expected 1", i, obs_ready[i]);
            else n_pass++;
            px_valid[i] = 1'b0;
        end
        cycle();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({obs_we[i], obs_x[i], obs_y[i], obs_pix[i]} !== {1'b1, 8'h12, 8'h34, 8'hE0})
                $display("FAIL pixel_write dut%0d: got we=%b x=%h y=%h pix=%h expected 1/12/34/e0",
                         i, obs_we[i], obs_x[i], obs_y[i], obs_pix[i]);
            else n_pass++;
        end
        cycle();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ({obs_we[i], obs_x[i]} !== {1'b0, 8'h12})
                $display("FAIL pixel_idle dut%0d: got we=%b x=%h expected we=0 x=12 held", i, obs_we[i], obs_x[i]);
            else n_pass++;
        end
    endtask

    // Random valid/hold pixel traffic; clear_start is also toggled when the fill engine is absent.
    task automatic test_random_pixels();
        int  accepted [N];
        int  seen     [N];
        int  busy_hit [N];
        bit  pending  [N];
        for (int i = 0; i < N; i++) begin
            accepted[i] = 0; seen[i] = 0; busy_hit[i] = 0; pending[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) begin
                    px_valid[i] = ($urandom_range(3) != 0);
                    if (px_valid[i]) new_pixel(i, 8'h00);
                    pending[i] = px_valid[i];
                end
                if (!CLEAR_EN) begin
                    clear_start[i] = ($urandom_range(15) == 0);
                    clear_color[i] = 8'($urandom);
                end
            end
            cycle();
            for (int i = 0; i < N; i++) begin
                if (px_valid[i] && grant_px[i]) begin
                    accepted[i]++;
                    pending[i] = 1'b0;
                end
                seen[i]     += int'(obs_we[i]);
                busy_hit[i] += int'(obs_busy[i] || obs_done[i]);
            end
        end
        for (int i = 0; i < N; i++) begin
            px_valid[i] = 1'b0; clear_start[i] = 1'b0;
        end
        repeat (2) begin
            cycle();
            for (int i = 0; i < N; i++) seen[i] += int'(obs_we[i]);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (seen[i] !== accepted[i])
                $display("FAIL random_write_count dut%0d: got %0d writes expected %0d", i, seen[i], accepted[i]);
            else n_pass++;
            n_checks++;
            if (busy_hit[i] !== 0)
                $display("FAIL random_no_clear dut%0d: got %0d busy/done cycles expected 0", i, busy_hit[i]);
            else n_pass++;
        end
    endtask

`ifdef FB_WRITE_SCHED_CLEAR_EN
    // dut0: pure sweep with a mid-sweep restart; dut1: 6 pixels interleaved;
    // dut2: 10 pixel cycles that freeze the fill, then reset at counter 0x8000.
    task automatic test_sweep();
        bit [7:0] col [N];
        int we0 = 0, first0 = -1, last0 = -1, order_err0 = 0, pix_err0 = 0, done0 = 0, done_k0 = -1, addr0 = 0;
        int fill_first1 = -1, fill_last1 = -1, px_w1 = 0, between1 = 0, done1 = 0, sent1 = 0;
        int px_w2 = 0, px_first2 = -1, px_last2 = -1, last_fill2 = -1, resume2 = -1, done2 = 0, sent2 = 0, rst_left2 = 0;
        bit restart0 = 0, burst1 = 0, burst2 = 0, rst2 = 0;
        col[0] = 8'h03; col[1] = 8'h5C; col[2] = 8'h1F;
        for (int i = 0; i < N; i++) begin
            clear_start[i] = 1'b1; clear_color[i] = col[i]; px_valid[i] = 1'b0;
        end
        for (int k = 0; k < 65600; k++) begin
            if (!restart0 && m[0].sweeping && m[0].cnt == 32'h4000) begin
                clear_start[0] = 1'b1; clear_color[0] = 8'hAA; restart0 = 1'b1;
            end
            if (!burst1 && m[1].sweeping && m[1].cnt == 32'h1000) begin
                burst1 = 1'b1; px_valid[1] = 1'b1; new_pixel(1, col[1]);
            end
            if (!burst2 && m[2].sweeping && m[2].cnt == 32'h2000) begin
                burst2 = 1'b1; px_valid[2] = 1'b1; new_pixel(2, col[2]);
            end
            if (!rst2 && m[2].sweeping && m[2].cnt == 32'h8000) begin
                rst2 = 1'b1; rst_n[2] = 1'b0; rst_left2 = 2;
            end
            cycle();
            for (int i = 0; i < N; i++) clear_start[i] = 1'b0;
            if (px_valid[1] && grant_px[1]) begin
                sent1++;
                if (sent1 == 6) px_valid[1] = 1'b0; else new_pixel(1, col[1]);
            end
            if (px_valid[2] && grant_px[2]) begin
                sent2++;
                if (sent2 == 10) px_valid[2] = 1'b0; else new_pixel(2, col[2]);
            end
            if (rst_left2 > 0) begin
                rst_left2--;
                if (rst_left2 == 0) begin
                    rst_n[2] = 1'b1;
                    n_checks++;
                    if ({obs_busy[2], obs_we[2]} !== 2'b00)
                        $display("FAIL reset_abort dut2: got busy=%b we=%b expected 0/0", obs_busy[2], obs_we[2]);
                    else n_pass++;
                end
            end
            if (obs_we[0]) begin
                we0++;
                if (first0 < 0) first0 = k;
                last0 = k;
                if ({obs_y[0], obs_x[0]} !== 16'(addr0)) order_err0++;
                if (obs_pix[0] !== 8'h03) pix_err0++;
                addr0++;
            end
            if (obs_done[0]) begin done0++; done_k0 = k; end
            if (obs_we[1]) begin
                if (obs_pix[1] == col[1]) begin
                    if (fill_first1 < 0) fill_first1 = k;
                    fill_last1 = k;
                    if (px_w1 > 0 && px_w1 < 6) between1++;
                end else px_w1++;
            end
            done1 += int'(obs_done[1]);
            if (obs_we[2]) begin
                if (obs_pix[2] == col[2]) begin
                    if (px_w2 == 0) last_fill2 = int'({obs_y[2], obs_x[2]});
                    else if (resume2 < 0) resume2 = int'({obs_y[2], obs_x[2]});
                end else begin
                    px_w2++;
                    if (px_first2 < 0) px_first2 = k;
                    px_last2 = k;
                end
            end
            done2 += int'(obs_done[2]);
        end
        n_checks++;
        if (we0 !== 65536) $display("FAIL sweep_count dut0: got %0d writes expected 65536", we0); else n_pass++;
        n_checks++;
        if (last0 - first0 + 1 !== 65536) $display("FAIL sweep_consecutive dut0: got span %0d expected 65536", last0 - first0 + 1); else n_pass++;
        n_checks++;
        if (order_err0 !== 0) $display("FAIL sweep_order dut0: got %0d address errors expected 0", order_err0); else n_pass++;
        n_checks++;
        if (pix_err0 !== 0) $display("FAIL sweep_color dut0: got %0d colour errors expected 0", pix_err0); else n_pass++;
        n_checks++;
        if (done0 !== 1) $display("FAIL sweep_done_count dut0: got %0d pulses expected 1", done0); else n_pass++;
        n_checks++;
        if (done_k0 !== last0) $display("FAIL sweep_done_time dut0: got cycle %0d expected %0d", done_k0, last0); else n_pass++;
        n_checks++;
        if (obs_busy[0] !== 1'b0) $display("FAIL sweep_busy_after dut0: got %b expected 0", obs_busy[0]); else n_pass++;
        n_checks++;
        if (fill_last1 - fill_first1 + 1 !== 65542)
            $display("FAIL rr_sweep_span dut1: got %0d cycles expected 65542", fill_last1 - fill_first1 + 1);
        else n_pass++;
        n_checks++;
        if ({px_w1, between1} !== {32'd6, 32'd5})
            $display("FAIL rr_alternate dut1: got %0d pixels/%0d interleaved fills expected 6/5", px_w1, between1);
        else n_pass++;
        n_checks++;
        if (done1 !== 1) $display("FAIL rr_done_count dut1: got %0d expected 1", done1); else n_pass++;
        n_checks++;
        if ({px_w2, px_last2 - px_first2 + 1} !== {32'd10, 32'd10})
            $display("FAIL fp_pixels dut2: got %0d pixels over %0d cycles expected 10/10", px_w2, px_last2 - px_first2 + 1);
        else n_pass++;
        n_checks++;
        if ({last_fill2, resume2} !== {32'h1FFF, 32'h2000})
            $display("FAIL fp_frozen dut2: got fill %h then %h expected 1fff then 2000", last_fill2, resume2);
        else n_pass++;
        n_checks++;
        if (done2 !== 0) $display("FAIL reset_no_done dut2: got %0d pulses expected 0", done2); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_pixel();
        test_random_pixels();
`ifdef FB_WRITE_SCHED_CLEAR_EN
        test_sweep();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 Parameter: ARB_RR, default 1; 1 = round-robin between pixel and clear requesters, 0 = fixed priority with the pixel requester winning.
REQ-002 Port: clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: px_valid  input  1  pixel requester has a write pending.
REQ-005 Port: px_x  input  8  pixel column.
REQ-006 Port: px_y  input  8  pixel row.
REQ-007 Port: px_pix  input  8  colour, RRRGGGBB.
REQ-008 Port: px_ready  output  1  pixel accepted this cycle; combinational from arbitration state and px_valid.
REQ-009 Port: clear_start  input  1  1-cycle strobe requesting a full-frame fill.
REQ-010 Port: clear_color  input  8  fill colour, sampled on accepted clear_start.
REQ-011 Port: clear_busy  output  1  fill sweep in progress.
REQ-012 Port: clear_done  output  1  1-cycle pulse after the final fill write is issued.
REQ-013 Port: wr_x, wr_y, wr_pix  output  8 each  registered framebuffer write address and data.
REQ-014 Port: wr_we  output  1  registered 1-cycle write strobe to the framebuffer write port.

Function
REQ-015 Clear FSM states: IDLE and SWEEP; clear_busy SHALL be 1 exactly when the state is SWEEP.
REQ-016 IDLE->SWEEP on clear_start=1: latch clear_color, clear the 16-bit sweep counter to 0x0000.
REQ-017 clear_start asserted while in SWEEP SHALL be ignored; colour and counter are unchanged.
REQ-018 Sweep address mapping: wr_y = counter[15:8], wr_x = counter[7:0] (raster order, x fastest).
REQ-019 On each granted fill write, the counter SHALL increment by 1; the grant at 0xFFFF SHALL return the FSM to IDLE, wrap the counter to 0, and assert clear_done on the next cycle.
REQ-020 One grant per cycle at most; requesters are px_valid and (state == SWEEP).
REQ-021 ARB_RR=1 with both requesting: grant SHALL alternate every cycle, starting with the requester not granted last. A sole requester SHALL be granted every cycle.
REQ-022 ARB_RR=0: pixel SHALL always win; fill writes proceed only on cycles with px_valid=0.
REQ-023 px_ready SHALL be 1 iff the pixel requester is granted; a transfer occurs when px_valid && px_ready; px_x/px_y/px_pix must be held stable by the source until then.
REQ-024 Latency: the granted request SHALL appear on wr_x/wr_y/wr_pix with wr_we=1 on the edge following the grant; with no grant, wr_we=0 and wr_x/wr_y/wr_pix hold their values.
REQ-025 Throughput: one framebuffer write per clk cycle, sustained.
REQ-026 A full sweep with no pixel traffic SHALL take exactly 65536 cycles from the first fill grant to the last.
REQ-027 clear_start in the same cycle as px_valid: the pixel SHALL be granted that cycle if ARB_RR=0 or if the last grant went to clear; the sweep starts next cycle regardless.

Reset
REQ-028 With rst_n=0 at a rising edge, the block SHALL reset to: state IDLE, counter 0, latched colour 0x00, RR pointer favouring pixel, wr_we=0, wr_x=wr_y=wr_pix=0x00, clear_done=0.
REQ-029 While rst_n=0, px_ready SHALL be 0.
REQ-030 Reset during SWEEP SHALL abort the sweep; no clear_done is pulsed.

Configuration
REQ-031 Macro FB_WRITE_SCHED_CLEAR_EN controls the clear engine.
REQ-032 Defined: the clear engine is built as specified above.
REQ-033 Undefined: no clear FSM; clear_start and clear_color are ignored; clear_busy=0 and clear_done=0 constantly; px_ready = px_valid (gated by reset); the pixel path keeps its 1-cycle latency.

Verification
REQ-034 Reset, then a pixel with x=0x12, y=0x34, pix=0xE0, px_valid=1 -> px_ready=1 that cycle; next cycle wr_we=1, wr_x=0x12, wr_y=0x34, wr_pix=0xE0; following cycle wr_we=0.
REQ-035 clear_start with clear_color=0x03 and no pixel traffic -> 65536 consecutive wr_we pulses with addresses 0x0000..0xFFFF (raster order) and wr_pix=0x03; clear_done pulses once after the last; clear_busy is 0 afterwards.
REQ-036 ARB_RR=1, sweep active, px_valid held high for 6 pixels -> grants alternate pixel/fill; the sweep completes in 65536+6 cycles.
REQ-037 ARB_RR=0, sweep active, px_valid high for 10 cycles -> 10 pixel writes; the fill counter is frozen during those 10 cycles.
REQ-038 Second clear_start mid-sweep at counter 0x4000 -> the sweep continues unchanged; clear_done pulses once only.
REQ-039 rst_n=0 at counter 0x8000 -> clear_busy=0, wr_we=0, and clear_done never pulses.
